// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers sharing one system clock.
// Config is double-buffered per channel and committed at a period boundary.
module multi_clock_divider #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 100_000,
  parameter int unsigned DEFAULT_HIGH   = 50_000,
  localparam int unsigned ChW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [NUM_CH-1:0] enable_i,
  input  logic              cfg_load_i,
  input  logic [ChW-1:0]    cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [CNT_W-1:0]  cfg_high_i,
  input  logic              sync_restart_i,
  output logic [NUM_CH-1:0] divided_clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic [CNT_W-1:0] cfg_period_clamped;

  assign cfg_period_clamped = (cfg_period_i < CNT_W'(2)) ? CNT_W'(2) : cfg_period_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sper_q, sper_d;
    logic [CNT_W-1:0] shigh_q, shigh_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             load_hit, pend_eff, wrap;
    logic [CNT_W-1:0] new_per, new_high;

    always_comb begin
      load_hit = cfg_load_i && (cfg_ch_i == ChW'(g));
      // A load in this cycle overrides any older shadow, so it is what a commit picks up.
      new_per  = load_hit ? cfg_period_clamped : sper_q;
      new_high = load_hit ? cfg_high_i : shigh_q;
      pend_eff = load_hit | pend_q;
      wrap     = cnt_q >= (per_q - CNT_W'(1));

      cnt_d   = cnt_q;
      per_d   = per_q;
      high_d  = high_q;
      sper_d  = new_per;
      shigh_d = new_high;
      pend_d  = pend_eff;
      div_d   = div_q;
      tick_d  = 1'b0;

      if (sync_restart_i) begin
        cnt_d = '0;
        if (pend_eff) begin
          per_d  = new_per;
          high_d = new_high;
          pend_d = 1'b0;
        end
        div_d = (high_d != '0);
      end else if (enable_i[g]) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_eff) begin
            per_d  = new_per;
            high_d = new_high;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        div_d = (cnt_d < high_d);
      end else if (pend_q) begin
        // Idle channel: commit the older shadow now; a load this cycle stays pending.
        per_d  = sper_q;
        high_d = shigh_q;
        pend_d = load_hit;
      end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        cnt_q   <= '0;
        per_q   <= CNT_W'(DEFAULT_PERIOD);
        high_q  <= CNT_W'(DEFAULT_HIGH);
        sper_q  <= CNT_W'(DEFAULT_PERIOD);
        shigh_q <= CNT_W'(DEFAULT_HIGH);
        pend_q  <= 1'b0;
        div_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        high_q  <= high_d;
        sper_q  <= sper_d;
        shigh_q <= shigh_d;
        pend_q  <= pend_d;
        div_q   <= div_d;
        tick_q  <= tick_d;
      end
    end

    assign divided_clk_o[g] = div_q;
    assign tick_o[g]        = tick_q;
  end

endmodule
